// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream packet arbiter family.
package axis_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for an N-entry selector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_picker.sv
// Round-robin priority encoder: returns the first set request at or after
// ptr_i, wrapping modulo N. The request vector is doubled and rotated right
// by ptr_i so that a plain lowest-index search yields the round-robin winner.
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] rot;
  int           sel;

  // Rotate, find the lowest set bit, then map back to an absolute index.
  always_comb begin
    rot     = N'({req_i, req_i} >> ptr_i);
    found_o = |rot;
    sel     = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) sel = j;
    end
    sel = sel + int'(ptr_i);
    if (sel >= N) sel = sel - N;
    idx_o = IW'(sel);
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI4-Stream sink between
// N_INPUTS sources. A granted source keeps the output until its tlast beat
// transfers; the arbitration decision is registered, so each packet pays a
// one-cycle IDLE bubble before its first beat.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 512
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]    i_data_tdata,
  input  logic [N_INPUTS-1:0][DATA_WIDTH/8-1:0]  i_data_tkeep,
  input  logic [N_INPUTS-1:0]                    i_data_tlast,
  input  logic [N_INPUTS-1:0]                    i_data_tvalid,
  output logic [N_INPUTS-1:0]                    i_data_tready,
  output logic [DATA_WIDTH-1:0]                  o_data_tdata,
  output logic [DATA_WIDTH/8-1:0]                o_data_tkeep,
  output logic                                   o_data_tlast,
  output logic                                   o_data_tvalid,
  input  logic                                   o_data_tready,
  output logic                                   o_busy,
  output logic [idx_width(N_INPUTS)-1:0]         o_grant_id,
  output logic                                   o_pkt_done
);

  localparam int IW = idx_width(N_INPUTS);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          pkt_done_q, pkt_done_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          granted;
  logic          src_valid;
  logic          xfer;

  rr_picker #(
    .N  (N_INPUTS),
    .IW (IW)
  ) u_picker (
    .req_i   (i_data_tvalid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign granted   = (state_q == GRANT);
  assign src_valid = i_data_tvalid[grant_q];
  assign xfer      = granted & src_valid & o_data_tready;

  // Control registers: state, round-robin pointer, grant index, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Next-state: pick a winner in IDLE, release the grant on the tlast beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    pkt_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer && i_data_tlast[grant_q]) begin
          state_d    = IDLE;
          pkt_done_d = 1'b1;
          // Just-served source drops to lowest priority next round.
          rr_ptr_d   = (grant_q == IW'(N_INPUTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pass-through datapath; handshakes are gated by rst so they fall with it.
  always_comb begin
    o_data_tdata  = i_data_tdata[grant_q];
    o_data_tkeep  = i_data_tkeep[grant_q];
    o_data_tlast  = i_data_tlast[grant_q];
    o_data_tvalid = granted & src_valid & ~rst;
    i_data_tready = '0;
    if (granted && !rst) i_data_tready[grant_q] = o_data_tready;
  end

  assign o_busy     = granted;
  assign o_grant_id = grant_q;
  assign o_pkt_done = pkt_done_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter (4 sources, 32-bit data).
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic                   clk;
  logic                   rst;
  logic [N-1:0][DW-1:0]   s_tdata;
  logic [N-1:0][KW-1:0]   s_tkeep;
  logic [N-1:0]           s_tlast;
  logic [N-1:0]           s_tvalid;
  logic [N-1:0]           s_tready;
  logic [DW-1:0]          m_tdata;
  logic [KW-1:0]          m_tkeep;
  logic                   m_tlast;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   busy;
  logic [1:0]             grant_id;
  logic                   pkt_done;

  axis_packet_arbiter #(
    .N_INPUTS   (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data_tdata  (s_tdata),
    .i_data_tkeep  (s_tkeep),
    .i_data_tlast  (s_tlast),
    .i_data_tvalid (s_tvalid),
    .i_data_tready (s_tready),
    .o_data_tdata  (m_tdata),
    .o_data_tkeep  (m_tkeep),
    .o_data_tlast  (m_tlast),
    .o_data_tvalid (m_tvalid),
    .o_data_tready (m_tready),
    .o_busy        (busy),
    .o_grant_id    (grant_id),
    .o_pkt_done    (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  beat_t         srcq [N][$];
  exp_t          expq [$];
  int            edges [$];
  logic [N-1:0]  hold;
  logic [N-1:0]  fire;
  int            n_chk, n_pass, cyc, done_cnt, model_ptr;
  logic          prev_stall, prev_tlast_xfer;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic add_beat(input int s, input logic [DW-1:0] d, input logic l);
    srcq[s].push_back('{data: d, last: l});
  endtask

  task automatic expect_beat(input int s, input logic [DW-1:0] d, input logic l);
    expq.push_back('{src: 2'(s), data: d, last: l});
  endtask

  function automatic int pending();
    int t = 0;
    for (int k = 0; k < N; k++) t += srcq[k].size();
    return t;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0 && !hold[k]) begin
        s_tvalid[k] = 1'b1;
        s_tdata[k]  = srcq[k][0].data;
        s_tlast[k]  = srcq[k][0].last;
      end else begin
        s_tvalid[k] = 1'b0;
        s_tdata[k]  = '0;
        s_tlast[k]  = 1'b0;
      end
      s_tkeep[k] = KW'(k + 1);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic x;
    fire = s_tvalid & s_tready;
    if (busy) chk("tready_map", s_tready, m_tready ? (N'(1) << grant_id) : N'(0));
    else      chk("idle_quiet", {s_tready, m_tvalid}, '0);
    if (prev_stall && m_tvalid) chk("stall_stable", m_tdata, prev_data);
    if (pkt_done) begin
      chk("done_after_last", prev_tlast_xfer, 1);
      done_cnt++;
    end
    x = m_tvalid && m_tready;
    if (x) begin
      if (expq.size() == 0) chk("extra_beat", m_tdata, 'hDEAD);
      else begin
        e = expq.pop_front();
        chk("tdata", m_tdata, e.data);
        chk("tlast", m_tlast, e.last);
        chk("grant_id", grant_id, e.src);
        chk("tkeep", m_tkeep, KW'(e.src + 1));
      end
      edges.push_back(cyc + 1);
    end
    prev_stall      = m_tvalid && !m_tready;
    prev_data       = m_tdata;
    prev_tlast_xfer = x && m_tlast;
  endtask

  task automatic step();
    beat_t dummy;
    drive_inputs();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (fire[k]) dummy = srcq[k].pop_front();
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((expq.size() > 0 || busy || pending() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", n < budget, 1);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int pat [4];
    n_chk = 0; n_pass = 0; cyc = 0; done_cnt = 0;
    prev_stall = 1'b0; prev_tlast_xfer = 1'b0; prev_data = '0;
    hold = '0; fire = '0;
    m_tready = 1'b1;
    rst = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", pkt_done, 0);
    rst = 1'b0;
    model_ptr = 0;

    // 3-beat packet from source 2
    c0 = cyc; edges.delete(); done_cnt = 0;
    add_beat(2, 'hA, 0); add_beat(2, 'hB, 0); add_beat(2, 'hC, 1);
    expect_beat(2, 'hA, 0); expect_beat(2, 'hB, 0); expect_beat(2, 'hC, 1);
    run_idle(50);
    chk("t1_nbeats", edges.size(), 3);
    if (edges.size() == 3) begin
      chk("t1_edge0", edges[0], c0 + 2);
      chk("t1_edge1", edges[1], c0 + 3);
      chk("t1_edge2", edges[2], c0 + 4);
    end
    chk("t1_done", done_cnt, 1);
    chk("t1_ptr", dut.rr_ptr_q, 3);
    model_ptr = 3;

    // All sources continuously send 2-beat packets
    c0 = cyc; edges.delete(); done_cnt = 0;
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++)
          add_beat(s, {8'(s), 8'(p), 8'(b), 8'hEE}, b == 1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 2; b++)
          expect_beat((model_ptr + i) % N, {8'((model_ptr + i) % N), 8'(r), 8'(b), 8'hEE}, b == 1);
    run_idle(200);
    chk("t2_done", done_cnt, 8);
    if (edges.size() > 0) chk("t2_last_edge", edges[edges.size() - 1], c0 + 24);
    chk("t2_ptr", dut.rr_ptr_q, model_ptr);

    // Granted source 1 stalls mid-packet while source 0 requests
    done_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      add_beat(1, {8'h31, 16'h0, 8'(b)}, b == 3);
      expect_beat(1, {8'h31, 16'h0, 8'(b)}, b == 3);
    end
    step();
    step();
    add_beat(0, 'hA0, 1);
    hold[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_grant", grant_id, 1);
      chk("t3_busy", busy, 1);
      chk("t3_src0_ready", s_tready[0], 0);
    end
    hold[1] = 1'b0;
    expect_beat(0, 'hA0, 1);
    run_idle(50);
    chk("t3_done", done_cnt, 2);
    chk("t3_ptr", dut.rr_ptr_q, 1);

    // Downstream backpressure 1,0,0,1 during a 4-beat packet
    edges.delete(); done_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      add_beat(2, 32'h40 + 32'(b), b == 3);
      expect_beat(2, 32'h40 + 32'(b), b == 3);
    end
    step();
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      m_tready = pat[i][0];
      step();
    end
    m_tready = 1'b1;
    run_idle(50);
    chk("t4_nbeats", edges.size(), 4);
    chk("t4_done", done_cnt, 1);
    chk("t4_ptr", dut.rr_ptr_q, 3);

    // Simultaneous single-beat packets from sources 3 and 0 with ptr=3
    c0 = cyc; edges.delete(); done_cnt = 0;
    add_beat(3, 'h33330001, 1);
    add_beat(0, 'h00000001, 1);
    expect_beat(3, 'h33330001, 1);
    expect_beat(0, 'h00000001, 1);
    run_idle(50);
    chk("t5_nbeats", edges.size(), 2);
    if (edges.size() == 2) begin
      chk("t5_edge0", edges[0], c0 + 2);
      chk("t5_edge1", edges[1], c0 + 4);
    end
    chk("t5_done", done_cnt, 2);
    chk("t5_ptr", dut.rr_ptr_q, 1);

    // Reset during the second beat of a 4-beat packet
    for (int b = 0; b < 4; b++) add_beat(1, 32'h61 + 32'(b), b == 3);
    expect_beat(1, 32'h61, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t6_tvalid", m_tvalid, 0);
    chk("t6_tready", s_tready, 0);
    chk("t6_busy", busy, 0);
    add_beat(0, 'h0600, 1);
    step();
    chk("t6_ptr", dut.rr_ptr_q, 0);
    chk("t6_grant", grant_id, 0);
    chk("t6_busy_hold", busy, 0);
    rst = 1'b0;
    expect_beat(0, 'h0600, 1);
    for (int b = 1; b < 4; b++) expect_beat(1, 32'h61 + 32'(b), b == 3);
    run_idle(50);
    chk("t6_ptr_end", dut.rr_ptr_q, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
